mmu_xlat: RTL and testbench
===========================

# mmu_xlat

Registered MIPS32 virtual-to-physical translation unit with a parametrised, fully associative TLB. kseg0 and kseg1 are fixed-mapped; kuseg, kseg2 and kseg3 are mapped through the TLB. It sits between the fetch/memory pipeline stages and the cache/bus interface. It accepts one translation per cycle over a valid/ready handshake and returns physical address, cacheability and TLB exception one cycle later.

## Interface
- NUM_ENTRIES, 8: number of TLB entries; power of two, 2–32.
- ASID_W, 8: ASID width.
- IDX_W, $clog2(NUM_ENTRIES): index width (derived).
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- req_valid  in  1  translation request valid.
- req_ready  out  1  unit can accept a request this cycle.
- req_vaddr  in  32  virtual address.
- req_write  in  1  access is a store (for the Modified check).
- asid  in  ASID_W  current EntryHi.ASID; sampled at accept.
- k0_uncached  in  1  Config.K0 == 2; sampled at accept.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer takes the response.
- resp_paddr  out  32  physical address.
- resp_uncached  out  1  access bypasses the cache.
- resp_exc  out  2  exception: 00 none, 01 refill (miss), 10 invalid, 11 modified.
- tlbw_en  in  1  write one TLB entry (TLBWI/TLBWR).
- tlbw_index  in  IDX_W  entry to write.
- tlbw_vpn2  in  19  VPN2 (vaddr[31:13]).
- tlbw_asid  in  ASID_W  entry ASID.
- tlbw_g  in  1  global bit.
- tlbw_lo0, tlbw_lo1  in  25  even and odd page: {PFN[19:0], C[2:0], D, V}.

## Operation
- An accept occurs when req_valid and req_ready are both high. The lookup result is loaded into the response register.
- req_ready = !resp_valid || resp_ready. This allows back-to-back throughput of one request per cycle.
- Segment decode on vaddr[31:29]:
  - 100 (kseg0): paddr = vaddr & 0x1FFF_FFFF; uncached = k0_uncached.
  - 101 (kseg1): paddr = vaddr & 0x1FFF_FFFF; uncached = 1.
  - All other segments are mapped.
- TLB match for a mapped address: entry.vpn2 == vaddr[31:13] and (entry.g or entry.asid == asid). vaddr[12] selects lo1 when 1, lo0 when 0.
- If several entries match, the lowest index wins. This is deterministic, not an error.
- Exception priority:
  - No match: exc = 01.
  - Selected V = 0: exc = 10.
  - req_write and D = 0: exc = 11.
  - Otherwise: exc = 00, paddr = {PFN, vaddr[11:0]}, uncached = (C == 3'd2).
- Whenever exc ≠ 00, resp_paddr and resp_uncached are 0.
- TLB write: tlbw_en writes all fields of entry tlbw_index at the clock edge.
- A request accepted in the same cycle as a write looks up the pre-write contents. The new entry is visible from the next accept onward.
- Writes are independent of the handshake and are never stalled.

## Timing
- Latency: accept in cycle N → resp_valid with result in cycle N+1.
- The response register holds its value while resp_valid && !resp_ready.
- If resp_ready && !req_valid, resp_valid drops next cycle.
- Values during reset (and after release until the first accept):
  - resp_valid = 0, resp_paddr = 0, resp_uncached = 0, resp_exc = 00.
  - Every TLB entry is cleared to all-zero (V0 = V1 = 0, G = 0), so every mapped lookup misses.
  - req_ready = 1.
- Reset asserted mid-transfer discards the pending response immediately.
- asid and k0_uncached changes affect only requests accepted after the change. A held response is not re-evaluated.

## Configuration
- MMU_XLAT_TLB_EN defined:
  - TLB storage and lookup as described above.
- MMU_XLAT_TLB_EN undefined:
  - No TLB storage; tlbw_* ports are ignored.
  - Mapped segments pass through unchanged: paddr = vaddr, uncached = 0, exc = 00.
  - kseg0/kseg1 decode, the handshake and the 1-cycle latency are unchanged.

## Test plan
- Reset, then request 0xBFC0_0000 → next cycle resp_paddr = 0x1FC0_0000, uncached = 1, exc = 00. With k0_uncached = 0, request 0x8000_1234 → 0x0000_1234, uncached = 0.
- Write entry 3 (vpn2 = 0x00200, asid = 5, g = 0, lo0 = {PFN 0x12345, C = 3, D = 1, V = 1}). With asid = 5, request 0x0040_0ABC → paddr 0x1234_5ABC, uncached = 0. Same request with asid = 6 → exc = 01, paddr = 0.
- Entry with lo1 V = 0: request 0x0040_1000 → exc = 10. Entry with lo0 D = 0, C = 2, V = 1: store to the even page → exc = 11; the same access as a load → uncached = 1, exc = 00.
- Hold resp_ready = 0 for 3 cycles with req_valid high → req_ready = 0 and the response stays stable. Release → back-to-back responses with no loss or duplication.
- tlbw_en and an accept in the same cycle on the same VPN → the response reflects the old entry (miss); the next request hits.
- Assert resetn low while resp_valid = 1 → resp_valid = 0 asynchronously, and all entries miss afterwards. Rebuild with MMU_XLAT_TLB_EN undefined → 0x0040_0ABC returns 0x0040_0ABC with exc = 00.

Source files
------------

// File: rtl/mmu_xlat_if.sv
// mmu_xlat_if: request/response bus between the pipeline and the MIPS32
// translation unit.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. A source holding valid high keeps its payload stable until
// that transfer. Ready may depend combinationally on the sink's state and on
// the downstream ready. It never depends on the upstream valid.
interface mmu_xlat_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        req_write;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_paddr;
  logic        resp_uncached;
  logic [1:0]  resp_exc;

  // Requester side: the pipeline issues requests and consumes responses.
  modport master (
    output req_valid, req_vaddr, req_write, resp_ready,
    input  req_ready, resp_valid, resp_paddr, resp_uncached, resp_exc
  );

  // Unit side: the translation unit.
  modport slave (
    input  req_valid, req_vaddr, req_write, resp_ready,
    output req_ready, resp_valid, resp_paddr, resp_uncached, resp_exc
  );
endinterface

// File: rtl/mmu_xlat.sv
// mmu_xlat: registered MIPS32 virtual-to-physical translation.
// kseg0 and kseg1 are fixed-mapped. kuseg, kseg2 and kseg3 go through a
// fully associative TLB. One request is accepted per cycle, and the result
// appears in the response register on the next cycle.
//
// Build option MMU_XLAT_TLB_EN:
//   defined   - TLB storage and lookup are present.
//   undefined - there is no TLB. Mapped segments pass through unchanged with
//               no exception, and the tlbw_* ports are ignored.
module mmu_xlat #(
  parameter int NUM_ENTRIES = 8,
  parameter int ASID_W      = 8,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic              clk,
  input  logic              resetn,
  mmu_xlat_if.slave         xif,
  input  logic [ASID_W-1:0] asid,
  input  logic              k0_uncached,
  input  logic              tlbw_en,
  input  logic [IDX_W-1:0]  tlbw_index,
  input  logic [18:0]       tlbw_vpn2,
  input  logic [ASID_W-1:0] tlbw_asid,
  input  logic              tlbw_g,
  input  logic [24:0]       tlbw_lo0,
  input  logic [24:0]       tlbw_lo1
);

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_REFILL  = 2'b01;
  localparam logic [1:0] EXC_INVALID = 2'b10;
  localparam logic [1:0] EXC_MOD     = 2'b11;

  logic        resp_valid_q;
  logic [31:0] resp_paddr_q;
  logic        resp_uncached_q;
  logic [1:0]  resp_exc_q;

  logic        accept;
  logic [31:0] vaddr;
  logic [31:0] map_paddr;
  logic        map_unc;
  logic [1:0]  map_exc;
  logic [31:0] nxt_paddr;
  logic        nxt_unc;
  logic [1:0]  nxt_exc;

  assign vaddr         = xif.req_vaddr;
  assign xif.req_ready = !resp_valid_q || xif.resp_ready;
  assign accept        = xif.req_valid && xif.req_ready;

`ifdef MMU_XLAT_TLB_EN
  logic [18:0]       tlb_vpn2 [NUM_ENTRIES];
  logic [ASID_W-1:0] tlb_asid [NUM_ENTRIES];
  logic              tlb_g    [NUM_ENTRIES];
  logic [24:0]       tlb_lo0  [NUM_ENTRIES];
  logic [24:0]       tlb_lo1  [NUM_ENTRIES];
  logic              hit;
  logic [24:0]       sel_lo;

  // TLB storage. Reset clears every entry so that all lookups miss.
  // A write lands at the edge, so a lookup in the same cycle sees old data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tlb_vpn2[i] <= '0;
        tlb_asid[i] <= '0;
        tlb_g[i]    <= 1'b0;
        tlb_lo0[i]  <= '0;
        tlb_lo1[i]  <= '0;
      end
    end else if (tlbw_en) begin
      tlb_vpn2[tlbw_index] <= tlbw_vpn2;
      tlb_asid[tlbw_index] <= tlbw_asid;
      tlb_g[tlbw_index]    <= tlbw_g;
      tlb_lo0[tlbw_index]  <= tlbw_lo0;
      tlb_lo1[tlbw_index]  <= tlbw_lo1;
    end
  end

  // Associative match. The lowest matching index wins, and vaddr[12] picks
  // the odd or even page.
  always_comb begin
    hit    = 1'b0;
    sel_lo = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!hit && tlb_vpn2[i] == vaddr[31:13] &&
          (tlb_g[i] || tlb_asid[i] == asid)) begin
        hit    = 1'b1;
        sel_lo = vaddr[12] ? tlb_lo1[i] : tlb_lo0[i];
      end
    end
  end

  // Exception priority is refill, then invalid, then modified. Address and
  // cacheability are zeroed on any exception.
  always_comb begin
    map_paddr = '0;
    map_unc   = 1'b0;
    map_exc   = EXC_NONE;
    if (!hit) begin
      map_exc = EXC_REFILL;
    end else if (!sel_lo[0]) begin
      map_exc = EXC_INVALID;
    end else if (xif.req_write && !sel_lo[1]) begin
      map_exc = EXC_MOD;
    end else begin
      map_paddr = {sel_lo[24:5], vaddr[11:0]};
      map_unc   = (sel_lo[4:2] == 3'd2);
    end
  end
`else
  logic unused_tlb;

  // Without a TLB, mapped segments are identity-mapped and cached.
  assign map_paddr  = vaddr;
  assign map_unc    = 1'b0;
  assign map_exc    = EXC_NONE;
  assign unused_tlb = ^{asid, xif.req_write, tlbw_en, tlbw_index, tlbw_vpn2,
                        tlbw_asid, tlbw_g, tlbw_lo0, tlbw_lo1};
`endif

  // Segment decode. kseg0 and kseg1 strip the top three bits. The remaining
  // segments take the mapped result.
  always_comb begin
    nxt_paddr = map_paddr;
    nxt_unc   = map_unc;
    nxt_exc   = map_exc;
    case (vaddr[31:29])
      3'b100: begin
        nxt_paddr = {3'b000, vaddr[28:0]};
        nxt_unc   = k0_uncached;
        nxt_exc   = EXC_NONE;
      end
      3'b101: begin
        nxt_paddr = {3'b000, vaddr[28:0]};
        nxt_unc   = 1'b1;
        nxt_exc   = EXC_NONE;
      end
      default: ;
    endcase
  end

  // Response register. It loads on accept, holds while stalled, and empties
  // once it is consumed with nothing new behind it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid_q    <= 1'b0;
      resp_paddr_q    <= '0;
      resp_uncached_q <= 1'b0;
      resp_exc_q      <= EXC_NONE;
    end else if (accept) begin
      resp_valid_q    <= 1'b1;
      resp_paddr_q    <= nxt_paddr;
      resp_uncached_q <= nxt_unc;
      resp_exc_q      <= nxt_exc;
    end else if (xif.resp_ready) begin
      resp_valid_q    <= 1'b0;
    end
  end

  assign xif.resp_valid    = resp_valid_q;
  assign xif.resp_paddr    = resp_paddr_q;
  assign xif.resp_uncached = resp_uncached_q;
  assign xif.resp_exc      = resp_exc_q;

endmodule

// File: tb/tb_mmu_xlat.sv
// tb_mmu_xlat: directed bench for mmu_xlat. It works with or without
// MMU_XLAT_TLB_EN defined. A reference model of the translation rules fills
// an expected-response queue, and a negedge compare process checks every
// cycle against the queue. Directed steps also check literal expectations.
module tb_mmu_xlat;
  localparam int NE = 8;
  localparam int AW = 8;
  localparam int IW = 3;
`ifdef MMU_XLAT_TLB_EN
  localparam bit TLB_ON = 1'b1;
`else
  localparam bit TLB_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mmu_xlat_if xif();
  logic [AW-1:0] asid;
  logic          k0_uncached;
  logic          tlbw_en;
  logic [IW-1:0] tlbw_index;
  logic [18:0]   tlbw_vpn2;
  logic [AW-1:0] tlbw_asid;
  logic          tlbw_g;
  logic [24:0]   tlbw_lo0;
  logic [24:0]   tlbw_lo1;

  mmu_xlat #(.NUM_ENTRIES(NE), .ASID_W(AW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .xif         (xif),
    .asid        (asid),
    .k0_uncached (k0_uncached),
    .tlbw_en     (tlbw_en),
    .tlbw_index  (tlbw_index),
    .tlbw_vpn2   (tlbw_vpn2),
    .tlbw_asid   (tlbw_asid),
    .tlbw_g      (tlbw_g),
    .tlbw_lo0    (tlbw_lo0),
    .tlbw_lo1    (tlbw_lo1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [18:0]   vpn2;
    logic [AW-1:0] asid;
    logic          g;
    logic [24:0]   lo0;
    logic [24:0]   lo1;
  } ent_t;

  ent_t        m_tlb [NE];
  logic [34:0] exp_q [$];   // {paddr, uncached, exc}
  bit          seen_accept;

  function automatic logic [34:0] model_xlat(logic [31:0] va, logic wr,
                                             logic [AW-1:0] as, logic k0);
    logic [34:0] r;
    bit          found;
    logic [24:0] lo;
    found = 1'b0;
    lo    = '0;
    if (va[31:29] == 3'b100) begin
      r = {3'b000, va[28:0], k0, 2'b00};
    end else if (va[31:29] == 3'b101) begin
      r = {3'b000, va[28:0], 1'b1, 2'b00};
    end else if (!TLB_ON) begin
      r = {va, 1'b0, 2'b00};
    end else begin
      for (int i = 0; i < NE; i++) begin
        if (!found && m_tlb[i].vpn2 == va[31:13] &&
            (m_tlb[i].g || m_tlb[i].asid == as)) begin
          found = 1'b1;
          lo    = va[12] ? m_tlb[i].lo1 : m_tlb[i].lo0;
        end
      end
      if (!found)            r = {32'd0, 1'b0, 2'b01};
      else if (!lo[0])       r = {32'd0, 1'b0, 2'b10};
      else if (wr && !lo[1]) r = {32'd0, 1'b0, 2'b11};
      else                   r = {lo[24:5], va[11:0], (lo[4:2] == 3'd2), 2'b00};
    end
    return r;
  endfunction

  // Model update at each edge: retire the consumed response, enqueue the
  // accepted lookup against the pre-write TLB, then apply any write.
  always @(posedge clk or negedge resetn) begin : model_p
    bit acc;
    if (!resetn) begin
      exp_q.delete();
      seen_accept = 1'b0;
      for (int i = 0; i < NE; i++) m_tlb[i] = '0;
    end else begin
      acc = xif.req_valid && (exp_q.size() == 0 || xif.resp_ready);
      if (exp_q.size() != 0 && xif.resp_ready) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(model_xlat(xif.req_vaddr, xif.req_write, asid, k0_uncached));
        seen_accept = 1'b1;
      end
      if (tlbw_en)
        m_tlb[tlbw_index] = '{vpn2: tlbw_vpn2, asid: tlbw_asid, g: tlbw_g,
                              lo0: tlbw_lo0, lo1: tlbw_lo1};
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : cmp_p
    bit          ev;
    logic [34:0] h;
    ev = (exp_q.size() != 0);
    check("sb_resp_valid", {31'd0, xif.resp_valid}, {31'd0, ev});
    check("sb_req_ready", {31'd0, xif.req_ready}, {31'd0, (!ev || xif.resp_ready)});
    if (ev) begin
      h = exp_q[0];
      check("sb_paddr", xif.resp_paddr, h[34:3]);
      check("sb_uncached", {31'd0, xif.resp_uncached}, {31'd0, h[2]});
      check("sb_exc", {30'd0, xif.resp_exc}, {30'd0, h[1:0]});
    end else if (!seen_accept) begin
      check("sb_idle_paddr", xif.resp_paddr, 32'd0);
      check("sb_idle_unc", {31'd0, xif.resp_uncached}, 32'd0);
      check("sb_idle_exc", {30'd0, xif.resp_exc}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then check the response literally on the next cycle.
  task automatic xact(string name, logic [31:0] va, logic wr,
                      logic [31:0] e_pa, logic e_unc, logic [1:0] e_exc);
    xif.req_valid = 1'b1;
    xif.req_vaddr = va;
    xif.req_write = wr;
    tick();
    xif.req_valid = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, {31'd0, xif.resp_valid}, 32'd1);
    check({name, "_paddr"}, xif.resp_paddr, e_pa);
    check({name, "_unc"}, {31'd0, xif.resp_uncached}, {31'd0, e_unc});
    check({name, "_exc"}, {30'd0, xif.resp_exc}, {30'd0, e_exc});
    tick();
  endtask

  task automatic tlb_write(logic [IW-1:0] idx, logic [18:0] vpn2, logic [AW-1:0] as,
                           logic g, logic [24:0] lo0, logic [24:0] lo1);
    tlbw_en    = 1'b1;
    tlbw_index = idx;
    tlbw_vpn2  = vpn2;
    tlbw_asid  = as;
    tlbw_g     = g;
    tlbw_lo0   = lo0;
    tlbw_lo1   = lo1;
    tick();
    tlbw_en = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    xif.req_valid  = 1'b0;
    xif.req_vaddr  = '0;
    xif.req_write  = 1'b0;
    xif.resp_ready = 1'b1;
    asid        = '0;
    k0_uncached = 1'b0;
    tlbw_en     = 1'b0;
    tlbw_index  = '0;
    tlbw_vpn2   = '0;
    tlbw_asid   = '0;
    tlbw_g      = 1'b0;
    tlbw_lo0    = '0;
    tlbw_lo1    = '0;

    // Reset values
    #12;
    check("rst_valid", {31'd0, xif.resp_valid}, 32'd0);
    check("rst_ready", {31'd0, xif.req_ready}, 32'd1);
    check("rst_paddr", xif.resp_paddr, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Fixed segments
    xact("kseg1", 32'hBFC0_0000, 1'b0, 32'h1FC0_0000, 1'b1, 2'b00);
    xact("kseg0_c", 32'h8000_1234, 1'b0, 32'h0000_1234, 1'b0, 2'b00);
    k0_uncached = 1'b1;
    xact("kseg0_u", 32'h8000_1234, 1'b0, 32'h0000_1234, 1'b1, 2'b00);
    k0_uncached = 1'b0;

    // Mapped lookups. Entry 3 has an odd page with V=0.
    tlb_write(3'd3, 19'h00200, 8'd5, 1'b0,
              {20'h12345, 3'd3, 1'b1, 1'b1}, {20'h0ABCD, 3'd3, 1'b1, 1'b0});
    asid = 8'd5;
    xact("hit", 32'h0040_0ABC, 1'b0, TLB_ON ? 32'h1234_5ABC : 32'h0040_0ABC, 1'b0,
         TLB_ON ? 2'b00 : 2'b00);
    asid = 8'd6;
    xact("asid_miss", 32'h0040_0ABC, 1'b0, TLB_ON ? 32'd0 : 32'h0040_0ABC, 1'b0,
         TLB_ON ? 2'b01 : 2'b00);
    asid = 8'd5;
    xact("invalid", 32'h0040_1000, 1'b0, TLB_ON ? 32'd0 : 32'h0040_1000, 1'b0,
         TLB_ON ? 2'b10 : 2'b00);
    xact("kseg2_miss", 32'hC000_0000, 1'b0, TLB_ON ? 32'd0 : 32'hC000_0000, 1'b0,
         TLB_ON ? 2'b01 : 2'b00);

    // Global entry 1 is clean and uncached.
    tlb_write(3'd1, 19'h00300, 8'd0, 1'b1,
              {20'h00077, 3'd2, 1'b0, 1'b1}, 25'd0);
    xact("modified", 32'h0060_0010, 1'b1, TLB_ON ? 32'd0 : 32'h0060_0010, 1'b0,
         TLB_ON ? 2'b11 : 2'b00);
    xact("load_unc", 32'h0060_0010, 1'b0, TLB_ON ? 32'h0007_7010 : 32'h0060_0010,
         TLB_ON, 2'b00);
    // Entry 0 covers the same page and wins because its index is lower.
    tlb_write(3'd0, 19'h00300, 8'd0, 1'b1,
              {20'h00055, 3'd3, 1'b1, 1'b1}, 25'd0);
    xact("low_idx", 32'h0060_0010, 1'b1, TLB_ON ? 32'h0005_5010 : 32'h0060_0010,
         1'b0, 2'b00);

    // A write and an accept in the same cycle: the lookup sees the old entry.
    tlbw_en    = 1'b1;
    tlbw_index = 3'd5;
    tlbw_vpn2  = 19'h01000;
    tlbw_asid  = 8'd5;
    tlbw_g     = 1'b0;
    tlbw_lo0   = {20'h00ABC, 3'd3, 1'b1, 1'b1};
    tlbw_lo1   = 25'd0;
    xif.req_valid = 1'b1;
    xif.req_vaddr = 32'h0200_0000;
    xif.req_write = 1'b0;
    tick();
    tlbw_en = 1'b0;
    xif.req_valid = 1'b0;
    @(negedge clk);
    check("wr_same_exc", {30'd0, xif.resp_exc}, TLB_ON ? 32'd1 : 32'd0);
    check("wr_same_pa", xif.resp_paddr, TLB_ON ? 32'd0 : 32'h0200_0000);
    tick();
    xact("wr_after", 32'h0200_0000, 1'b0, TLB_ON ? 32'h00AB_C000 : 32'h0200_0000,
         1'b0, 2'b00);

    // Backpressure. A is held for 3 cycles while B waits, and a k0 change
    // during the hold must not alter A.
    xif.resp_ready = 1'b0;
    xif.req_valid  = 1'b1;
    xif.req_vaddr  = 32'h8000_0100;
    tick();
    xif.req_vaddr = 32'hA000_0200;
    k0_uncached   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", {31'd0, xif.req_ready}, 32'd0);
      check("bp_hold_pa", xif.resp_paddr, 32'h0000_0100);
      check("bp_hold_unc", {31'd0, xif.resp_uncached}, 32'd0);
      tick();
    end
    k0_uncached    = 1'b0;
    xif.resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) xif.req_valid = 1'b0;
      else        xif.req_vaddr = 32'hA000_0204 + 32'(i * 4);
      @(negedge clk);
      check("b2b_pa", xif.resp_paddr, 32'h0000_0200 + 32'(i * 4));
      check("b2b_valid", {31'd0, xif.resp_valid}, 32'd1);
    end
    tick();

    // Reset while a response is held
    xif.resp_ready = 1'b0;
    xif.req_valid  = 1'b1;
    xif.req_vaddr  = 32'hA000_0040;
    tick();
    xif.req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", {31'd0, xif.resp_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, xif.resp_valid}, 32'd0);
    check("async_rst_pa", xif.resp_paddr, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    xif.resp_ready = 1'b1;
    xact("post_rst", 32'h0040_0ABC, 1'b0, TLB_ON ? 32'd0 : 32'h0040_0ABC, 1'b0,
         TLB_ON ? 2'b01 : 2'b00);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
